dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache controller sitting directly upstream of the mem stage. Accepts load/store requests from the execute stage and returns the full 128-bit cache line plus the registered word selector consumed by mem. Misses stall the pipeline while a single-outstanding refill (and dirty victim writeback) runs against the 128-bit memory port.

---
 rtl/dcache_pkg.sv | 31 +++
 rtl/dcache_merge.sv | 30 +++
 rtl/dcache_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// +----------------------------------------------------------------------+
// | dcache_pkg: shared types, store encodings and geometry helpers        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB   = 2'd1,
      FILL = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic [1:0] WT_READ = 2'b00;
   localparam logic [1:0] WT_W32  = 2'b01;
   localparam logic [1:0] WT_W36  = 2'b10;
   localparam logic [1:0] WT_W128 = 2'b11;

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int addr_w, input int sets);
      return addr_w - 2 - $clog2(sets);
   endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_merge.sv
// +----------------------------------------------------------------------+
// | dcache_merge: combinational store-data merge into a 128-bit line      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module dcache_merge
   import dcache_pkg::*;
(
   input  logic [127:0] line_in,
   input  logic [127:0] wdata,
   input  logic [1:0]   w_type,
   input  logic [1:0]   word_sel,
   output logic [127:0] line_out
);

   always_comb begin
      line_out = line_in;
      case (w_type)
         WT_W32:  line_out[{word_sel, 5'd0} +: 32] = wdata[31:0];
         // 36-bit stores land at the bottom of the selected 64-bit half
         WT_W36:  line_out[{word_sel[1], 6'd0} +: 36] = wdata[35:0];
         WT_W128: line_out = wdata;
         default: line_out = line_in;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// +----------------------------------------------------------------------+
// | dcache_ctrl: direct-mapped write-back/write-allocate D-cache control  |
// | Optional DCACHE_STATS_EN adds hit_cnt/miss_cnt outputs. Rev 1.0       |
// +----------------------------------------------------------------------+
`default_nettype none

module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int SETS   = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [1:0]        w_type,
   input  logic [ADDR_W-1:0] addr,
   input  logic [127:0]      wdata,
   output logic              stall,
   output logic              resp_valid,
   output logic [127:0]      cache_data,
   output logic [1:0]        line,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [127:0]      mem_wdata,
`ifdef DCACHE_STATS_EN
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt,
`endif
   input  logic              mem_ready,
   input  logic [127:0]      mem_rdata
);

   localparam int IDX_W = idx_w(SETS);
   localparam int TAG_W = tag_w(ADDR_W, SETS);

   logic [127:0]      data_q [SETS];
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [SETS-1:0]   valid_q, valid_d;
   logic [SETS-1:0]   dirty_q, dirty_d;

   state_t            state_q, state_d;
   logic              stall_q, stall_d;
   logic              resp_valid_q, resp_valid_d;
   logic [127:0]      cache_data_q, cache_data_d;
   logic [1:0]        line_q, line_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
   logic [127:0]      mem_wdata_q, mem_wdata_d;

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic              hit;
   logic              is_store;
   logic              mem_done;
   logic              miss_now;
   logic              arr_we;
   logic [127:0]      merge_base;
   logic [127:0]      merged;

   assign idx      = addr[IDX_W+1:2];
   assign tag      = addr[ADDR_W-1:IDX_W+2];
   assign hit      = valid_q[idx] && (tag_q[idx] == tag);
   assign is_store = (w_type != WT_READ);
   assign mem_done = mem_req_q && mem_ready;
   assign miss_now = (state_q == IDLE) && req && !hit;

   // The fill path merges the store into the incoming line, the hit path into the stored one
   assign merge_base = (state_q == FILL) ? mem_rdata : data_q[idx];

   dcache_merge u_merge (
      .line_in  (merge_base),
      .wdata    (wdata),
      .w_type   (w_type),
      .word_sel (addr[1:0]),
      .line_out (merged)
   );

   always_comb begin
      state_d      = state_q;
      stall_d      = stall_q;
      resp_valid_d = 1'b0;
      cache_data_d = cache_data_q;
      line_d       = line_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      arr_we       = 1'b0;

      case (state_q)
         IDLE: begin
            if (req && hit) begin
               resp_valid_d = 1'b1;
               cache_data_d = merged;
               line_d       = addr[1:0];
               if (is_store) begin
                  arr_we       = 1'b1;
                  dirty_d[idx] = 1'b1;
               end
            end else if (req) begin
               stall_d   = 1'b1;
               mem_req_d = 1'b1;
               if (valid_q[idx] && dirty_q[idx]) begin
                  state_d     = WB;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = {tag_q[idx], idx};
                  mem_wdata_d = data_q[idx];
               end else begin
                  state_d    = FILL;
                  mem_we_d   = 1'b0;
                  mem_addr_d = addr[ADDR_W-1:2];
               end
            end
         end
         WB: begin
            if (mem_done) begin
               dirty_d[idx] = 1'b0;
               mem_we_d     = 1'b0;
               mem_addr_d   = addr[ADDR_W-1:2];
               state_d      = FILL;
            end
         end
         FILL: begin
            if (mem_done) begin
               arr_we       = 1'b1;
               valid_d[idx] = 1'b1;
               dirty_d[idx] = is_store;
               mem_req_d    = 1'b0;
               stall_d      = 1'b0;
               resp_valid_d = 1'b1;
               cache_data_d = merged;
               line_d       = addr[1:0];
               state_d      = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         stall_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         cache_data_q <= '0;
         line_q       <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         valid_q      <= '0;
         dirty_q      <= '0;
      end else begin
         state_q      <= state_d;
         stall_q      <= stall_d;
         resp_valid_q <= resp_valid_d;
         cache_data_q <= cache_data_d;
         line_q       <= line_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (arr_we) begin
         data_q[idx] <= merged;
         tag_q[idx]  <= tag;
      end
   end

   // Miss-detect stall is combinational; masked while reset is held
   assign stall      = stall_q || (miss_now && rst);
   assign resp_valid = resp_valid_q;
   assign cache_data = cache_data_q;
   assign line       = line_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

`ifdef DCACHE_STATS_EN
   logic        hit_now;
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   assign hit_now = (state_q == IDLE) && req && hit;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (hit_now && (hit_cnt_q != 32'hFFFF_FFFF)) begin
         hit_cnt_d = hit_cnt_q + 32'd1;
      end
      if (miss_now && (miss_cnt_q != 32'hFFFF_FFFF)) begin
         miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_dcache_ctrl: scoreboard bench for dcache_ctrl with a memory model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dcache_ctrl;

   localparam int ADDR_W = 32;
   localparam int SETS   = 64;

   typedef struct {
      logic         we;
      logic [29:0]  addr;
      logic [127:0] wdata;
      logic [127:0] rdata;
   } mem_t;

   typedef struct {
      logic [127:0] data;
      logic [1:0]   ln;
   } resp_t;

   logic              clk;
   logic              rst;
   logic              req;
   logic [1:0]        w_type;
   logic [ADDR_W-1:0] addr;
   logic [127:0]      wdata;
   logic              stall;
   logic              resp_valid;
   logic [127:0]      cache_data;
   logic [1:0]        line;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-3:0] mem_addr;
   logic [127:0]      mem_wdata;
   logic              mem_ready;
   logic [127:0]      mem_rdata;

   mem_t  exp_mem[$];
   resp_t exp_resp[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    mem_delay = 0;

   localparam logic [127:0] L0 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
   localparam logic [127:0] L1 = 128'hDDDDDDDD_DEADBEEF_BBBBBBBB_AAAAAAAA;
   localparam logic [127:0] L2 = 128'hDDDDDDDF_12345678_BBBBBBBB_AAAAAAAA;
   localparam logic [127:0] L3 = 128'hDDDDDDDF_12345678_BBBBBBB0_00001111;
   localparam logic [127:0] L4 = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] LW = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] L5 = 128'h55555555_55555555_55555555_55555555;
   localparam logic [127:0] L6 = 128'h66666666_66666666_66666666_66666666;
   localparam logic [127:0] L6S = 128'h66666666_66666666_12345678_66666666;
   localparam logic [127:0] L7 = 128'h77777777_77777777_77777777_77777777;

   dcache_ctrl #(
      .ADDR_W (ADDR_W),
      .SETS   (SETS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .w_type     (w_type),
      .addr       (addr),
      .wdata      (wdata),
      .stall      (stall),
      .resp_valid (resp_valid),
      .cache_data (cache_data),
      .line       (line),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic exp_fill(input logic [29:0] a, input logic [127:0] rd);
      mem_t m;
      m.we = 1'b0; m.addr = a; m.wdata = '0; m.rdata = rd;
      exp_mem.push_back(m);
   endtask

   task automatic exp_wb(input logic [29:0] a, input logic [127:0] wd);
      mem_t m;
      m.we = 1'b1; m.addr = a; m.wdata = wd; m.rdata = '0;
      exp_mem.push_back(m);
   endtask

   task automatic exp_rsp(input logic [127:0] d, input logic [1:0] ln);
      resp_t r;
      r.data = d; r.ln = ln;
      exp_resp.push_back(r);
   endtask

   // Holds the request until the cache stops stalling; checks the stalled-cycle count
   task automatic issue(input string nm, input logic [1:0] wt, input logic [31:0] a,
                        input logic [127:0] wd, input int exp_stall);
      int   cyc;
      logic s;
      req = 1'b1; w_type = wt; addr = a; wdata = wd;
      cyc = 0;
      do begin
         @(negedge clk);
         s = stall;
         if (s) cyc++;
         @(posedge clk);
         #1;
      end while (s && cyc < 200);
      if (s) begin
         n_cmp++; n_err++;
         $display("FAIL %s_timeout: stall still high after %0d cycles, required release", nm, cyc);
      end else begin
         chk({nm, "_stall_cycles"}, 128'(cyc), 128'(exp_stall));
      end
      req = 1'b0;
   endtask

   // Response monitor
   initial begin : monitor
      resp_t r;
      forever begin
         @(negedge clk);
         if (rst && resp_valid) begin
            if (exp_resp.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL resp_unexpected: got data %h line %0d, required no response", cache_data, line);
            end else begin
               r = exp_resp.pop_front();
               chk("resp_data", cache_data, r.data);
               chk("resp_line", 128'(line), 128'(r.ln));
            end
         end
      end
   end

   // Memory model: checks each request against the expected queue, answers after mem_delay
   initial begin : mem_model
      mem_t m;
      logic aborted;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst && mem_req) begin
            if (exp_mem.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL mem_unexpected: got we %0d addr %h, required no memory traffic", mem_we, mem_addr);
               m.we = mem_we; m.addr = mem_addr; m.wdata = '0; m.rdata = '0;
            end else begin
               m = exp_mem.pop_front();
               chk("mem_we", 128'(mem_we), 128'(m.we));
               chk("mem_addr", 128'(mem_addr), 128'(m.addr));
               if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
            end
            aborted = 1'b0;
            for (int i = 0; i < mem_delay; i++) begin
               @(negedge clk);
               if (!rst) begin
                  aborted = 1'b1;
                  break;
               end
            end
            if (!aborted) begin
               @(posedge clk);
               #1;
               mem_ready = 1'b1;
               mem_rdata = m.rdata;
               @(posedge clk);
               #1;
               mem_ready = 1'b0;
               mem_rdata = '0;
            end
         end
      end
   end

   initial begin : stimulus
      rst = 1'b1; req = 1'b0; w_type = 2'b00; addr = '0; wdata = '0;
      #3 rst = 1'b0;
      #4;
      chk("rst_stall", 128'(stall), 128'(0));
      chk("rst_resp_valid", 128'(resp_valid), 128'(0));
      chk("rst_mem_req", 128'(mem_req), 128'(0));
      chk("rst_mem_we", 128'(mem_we), 128'(0));
      chk("rst_line", 128'(line), 128'(0));
      chk("rst_cache_data", cache_data, 128'(0));
      chk("rst_mem_addr", 128'(mem_addr), 128'(0));
      chk("rst_mem_wdata", mem_wdata, 128'(0));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      mem_delay = 2;
      exp_fill(30'h40, L0); exp_rsp(L0, 2'd0);
      issue("cold_read", 2'b00, 32'h100, '0, 5);

      exp_rsp(L0, 2'd1);
      issue("hit_read", 2'b00, 32'h101, '0, 0);

      exp_rsp(L1, 2'd2);
      issue("st32_hit", 2'b01, 32'h102, 128'hFFFF_0000_1111_2222_3333_4444_DEAD_BEEF, 0);
      exp_rsp(L1, 2'd2);
      issue("read_st32", 2'b00, 32'h102, '0, 0);

      exp_rsp(L2, 2'd3);
      issue("st36_hi", 2'b10, 32'h103, {92'hABC_DEF0_1234_5678_9ABC_DEF0, 36'hF_1234_5678}, 0);
      exp_rsp(L3, 2'd1);
      issue("st36_lo", 2'b10, 32'h101, {92'h999_8888_7777_6666_5555_4444, 36'h0_0000_1111}, 0);

      mem_delay = 5;
      exp_wb(30'h40, L3); exp_fill(30'h80, L4); exp_rsp(L4, 2'd0);
      issue("conflict_wb", 2'b00, 32'h200, '0, 15);

      mem_delay = 0;
      exp_fill(30'hC0, L5); exp_rsp(LW, 2'd1);
      issue("st128_miss", 2'b11, 32'h301, LW, 3);

      exp_fill(30'h11, L6); exp_rsp(L6S, 2'd1);
      issue("st32_miss", 2'b01, 32'h045, 128'h1234_5678, 3);

      exp_rsp(LW, 2'd1);
      issue("read_st128", 2'b00, 32'h301, '0, 0);

      // Reset while a refill is outstanding
      mem_delay = 20;
      exp_fill(30'h20, L7);
      req = 1'b1; w_type = 2'b00; addr = 32'h080; wdata = '0;
      repeat (4) @(negedge clk);
      chk("fill_mem_req", 128'(mem_req), 128'(1));
      #2 rst = 1'b0;
      #1;
      chk("midrst_mem_req", 128'(mem_req), 128'(0));
      chk("midrst_stall", 128'(stall), 128'(0));
      chk("midrst_resp_valid", 128'(resp_valid), 128'(0));
      chk("midrst_line", 128'(line), 128'(0));
      req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      mem_delay = 1;
      exp_fill(30'h40, L7); exp_rsp(L7, 2'd1);
      issue("post_rst_miss", 2'b00, 32'h101, '0, 4);

      repeat (4) @(posedge clk);
      #1;
      chk("resp_queue_empty", 128'(exp_resp.size()), 128'(0));
      chk("mem_queue_empty", 128'(exp_mem.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
